// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle multiply/divide engine for the EX stage.
// Unsigned 32-iteration shift-add multiply (operation 5'hf) and signed
// restoring divide (operation 5'h10), results held in HI/LO.
// Optional build macro: MULDIV_EARLY_TERM_EN lets the multiply finish as soon
// as the remaining multiplier bits are all zero.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4:0]           operation,
    input  logic [WIDTH-1:0]     Op1,
    input  logic [WIDTH-1:0]     Op2,
    input  logic                 abort,
    output logic                 busy,
    output logic                 stall,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [WIDTH-1:0]     HI,
    output logic [WIDTH-1:0]     LO,
    output logic [2*WIDTH-1:0]   EXE_Result
);

    localparam logic [4:0]       OP_MUL   = 5'h0f;
    localparam logic [4:0]       OP_DIV   = 5'h10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t               state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [2*WIDTH-1:0]   acc_reg;       // multiply accumulator
    logic [WIDTH-1:0]     mcand_reg;     // multiplicand
    logic [WIDTH-1:0]     mplier_reg;    // remaining multiplier bits
    logic [WIDTH-1:0]     rem_reg;       // partial remainder (magnitude)
    logic [WIDTH-1:0]     quo_reg;       // dividend bits shifting out / quotient shifting in
    logic [WIDTH-1:0]     divisor_reg;   // divisor magnitude
    logic                 neg_quo_reg;
    logic                 neg_rem_reg;
    logic [WIDTH-1:0]     hi_reg;
    logic [WIDTH-1:0]     lo_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 dbz_reg;

    logic                 is_mul_op;
    logic                 is_div_op;
    logic                 start_ok;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 last_iter;
    logic [WIDTH:0]       add_sum;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       rem_diff;
    logic                 q_bit;
    logic [WIDTH-1:0]     rem_new;
    logic [WIDTH-1:0]     quo_new;
    logic [WIDTH-1:0]     op1_abs;
    logic [WIDTH-1:0]     op2_abs;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
`ifdef MULDIV_EARLY_TERM_EN
    logic [2*WIDTH-1:0]   acc_aligned;   // accumulator aligned after an early exit
    logic [2*WIDTH-1:0]   acc_idle_aligned;
`endif

    // Datapath: one multiply step, one restoring-divide step and sign fix-up.
    always_comb begin
        is_mul_op = (operation == OP_MUL);
        is_div_op = (operation == OP_DIV);
        start_ok  = start && (is_mul_op || is_div_op) && (state_reg == S_IDLE);

        cnt_inc   = cnt_reg + 1'b1;
        last_iter = (cnt_inc == CNT_LAST);

        // Add into the upper half with a carry bit, then shift the whole
        // accumulator (carry included) right by one.
        add_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                  + (mplier_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
        acc_step  = {add_sum, acc_reg[WIDTH-1:1]};

        // Trial subtraction; no borrow means the quotient bit is 1.
        rem_shift = {rem_reg, quo_reg[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, divisor_reg};
        q_bit     = ~rem_diff[WIDTH];
        rem_new   = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_new   = {quo_reg[WIDTH-2:0], q_bit};

        op1_abs   = Op1[WIDTH-1] ? -Op1 : Op1;
        op2_abs   = Op2[WIDTH-1] ? -Op2 : Op2;

        // Most-negative / -1 lands here as 0x80000000 and wraps harmlessly.
        quo_fix   = neg_quo_reg ? -quo_reg : quo_reg;
        rem_fix   = neg_rem_reg ? -rem_reg : rem_reg;

`ifdef MULDIV_EARLY_TERM_EN
        // After k iterations the accumulator holds product << (WIDTH-k).
        acc_aligned      = acc_step >> (CNT_LAST - cnt_inc);
        acc_idle_aligned = acc_reg >> (CNT_LAST - cnt_reg);
`endif
    end

    // Sequencer FSM with registered busy/done/div_by_zero and HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            neg_quo_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            dbz_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (is_mul_op) begin
                            mcand_reg  <= Op1;
                            mplier_reg <= Op2;
                            acc_reg    <= '0;
                            cnt_reg    <= '0;
                            dbz_reg    <= 1'b0;
                            busy_reg   <= 1'b1;
                            state_reg  <= S_MUL;
                        end else if (is_div_op) begin
                            if (Op2 == '0) begin
                                hi_reg    <= Op1;
                                lo_reg    <= '1;
                                dbz_reg   <= 1'b1;
                                done_reg  <= 1'b1;
                                state_reg <= S_DONE;
                            end else begin
                                rem_reg     <= '0;
                                quo_reg     <= op1_abs;
                                divisor_reg <= op2_abs;
                                neg_quo_reg <= Op1[WIDTH-1] ^ Op2[WIDTH-1];
                                neg_rem_reg <= Op1[WIDTH-1];
                                cnt_reg     <= '0;
                                dbz_reg     <= 1'b0;
                                busy_reg    <= 1'b1;
                                state_reg   <= S_DIV;
                            end
                        end
                    end
                end
                S_MUL: begin
                    if (abort) begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
`ifdef MULDIV_EARLY_TERM_EN
                        if (mplier_reg == '0) begin
                            // Only reachable with a zero multiplier on entry.
                            {hi_reg, lo_reg} <= acc_idle_aligned;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= S_DONE;
                        end else begin
                            acc_reg    <= acc_step;
                            mplier_reg <= mplier_reg >> 1;
                            cnt_reg    <= cnt_inc;
                            if (last_iter || ((mplier_reg >> 1) == '0)) begin
                                {hi_reg, lo_reg} <= acc_aligned;
                                done_reg  <= 1'b1;
                                busy_reg  <= 1'b0;
                                state_reg <= S_DONE;
                            end
                        end
`else
                        acc_reg    <= acc_step;
                        mplier_reg <= mplier_reg >> 1;
                        cnt_reg    <= cnt_inc;
                        if (last_iter) begin
                            {hi_reg, lo_reg} <= acc_step;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= S_DONE;
                        end
`endif
                    end
                end
                S_DIV: begin
                    if (abort) begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        rem_reg <= rem_new;
                        quo_reg <= quo_new;
                        cnt_reg <= cnt_inc;
                        if (last_iter) begin
                            state_reg <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (abort) begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        hi_reg    <= rem_fix;
                        lo_reg    <= quo_fix;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Result already committed; abort and start are ignored here.
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign stall       = busy_reg || start_ok;
    assign done        = done_reg;
    assign div_by_zero = dbz_reg;
    assign HI          = hi_reg;
    assign LO          = lo_reg;
    assign EXE_Result  = {hi_reg, lo_reg};

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer (default or MULDIV_EARLY_TERM_EN build).
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  operation;
    logic [31:0] Op1;
    logic [31:0] Op2;
    logic        abort;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div_by_zero;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [63:0] EXE_Result;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    muldiv_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .operation   (operation),
        .Op1         (Op1),
        .Op2         (Op2),
        .abort       (abort),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .div_by_zero (div_by_zero),
        .HI          (HI),
        .LO          (LO),
        .EXE_Result  (EXE_Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation at cycle 0; returns in the done cycle (or after the bound).
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cnt, output logic stall0,
                          output logic dbz1);
        start = 1'b1; operation = op; Op1 = a; Op2 = b;
        #1 stall0 = stall;
        tick();
        start = 1'b0; operation = 5'h00; Op1 = ~a; Op2 = ~b;
        lat = -1; busy_cnt = 0; dbz1 = div_by_zero;
        for (int n = 1; n <= 60; n++) begin
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (busy === 1'b1) busy_cnt = busy_cnt + 1;
            tick();
        end
        $display("op=%h Op1=%h Op2=%h -> HI=%h LO=%h latency=%0d busy_cycles=%0d dbz=%b",
                 op, a, b, HI, LO, lat, busy_cnt, div_by_zero);
    endtask

    initial begin
        int lat;
        int bcnt;
        int seen;
        logic st0;
        logic dbz1;

        rst = 1'b1; start = 1'b0; operation = 5'h00; Op1 = '0; Op2 = '0; abort = 1'b0;
        #2;
        chk("reset_busy",  {63'd0, busy},        64'd0);
        chk("reset_done",  {63'd0, done},        64'd0);
        chk("reset_dbz",   {63'd0, div_by_zero}, 64'd0);
        chk("reset_stall", {63'd0, stall},       64'd0);
        chk("reset_exe",   EXE_Result,           64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Full-width multiply
        run_op(5'h0f, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt, st0, dbz1);
        chk("mulmax_latency", 64'(lat),  64'd33);
        chk("mulmax_busycnt", 64'(bcnt), 64'd32);
        chk("mulmax_stall0",  {63'd0, st0}, 64'd1);
        chk("mulmax_hi",      {32'd0, HI},  64'h0000_0000_FFFF_FFFE);
        chk("mulmax_lo",      {32'd0, LO},  64'h0000_0000_0000_0001);
        chk("mulmax_exe",     EXE_Result,   64'hFFFF_FFFE_0000_0001);
        chk("mulmax_busy_in_done", {63'd0, busy}, 64'd0);
        tick();
        chk("mulmax_done_pulse", {63'd0, done}, 64'd0);

        // Reset in the middle of a multiply
        start = 1'b1; operation = 5'h0f; Op1 = 32'd7; Op2 = 32'hFFFF_FFFF;
        tick();
        start = 1'b0; operation = 5'h00;
        repeat (9) tick();
        #2 rst = 1'b1;
        #1;
        chk("rstmid_busy", {63'd0, busy}, 64'd0);
        chk("rstmid_done", {63'd0, done}, 64'd0);
        chk("rstmid_hi",   {32'd0, HI},   64'd0);
        chk("rstmid_lo",   {32'd0, LO},   64'd0);
        #2 rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (done === 1'b1) seen = seen + 1;
        end
        chk("rstmid_no_done", 64'(seen), 64'd0);

        // Signed divide -7 / 2
        run_op(5'h10, 32'hFFFF_FFF9, 32'h0000_0002, lat, bcnt, st0, dbz1);
        chk("divneg_latency", 64'(lat),  64'd34);
        chk("divneg_busycnt", 64'(bcnt), 64'd33);
        chk("divneg_lo",      {32'd0, LO}, 64'h0000_0000_FFFF_FFFD);
        chk("divneg_hi",      {32'd0, HI}, 64'h0000_0000_FFFF_FFFF);
        tick();

        // Most-negative / -1 wraps
        run_op(5'h10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt, st0, dbz1);
        chk("divwrap_latency", 64'(lat), 64'd34);
        chk("divwrap_lo", {32'd0, LO}, 64'h0000_0000_8000_0000);
        chk("divwrap_hi", {32'd0, HI}, 64'd0);
        tick();

        // Divide by zero
        run_op(5'h10, 32'd100, 32'd0, lat, bcnt, st0, dbz1);
        chk("dbz_latency", 64'(lat), 64'd1);
        chk("dbz_flag",    {63'd0, div_by_zero}, 64'd1);
        chk("dbz_hi",      {32'd0, HI}, 64'd100);
        chk("dbz_lo",      {32'd0, LO}, 64'h0000_0000_FFFF_FFFF);
        chk("dbz_busycnt", 64'(bcnt), 64'd0);
        tick();
        chk("dbz_flag_held", {63'd0, div_by_zero}, 64'd1);

        // Next valid start clears the flag; leaves HI:LO = 0:6
        run_op(5'h0f, 32'd2, 32'd3, lat, bcnt, st0, dbz1);
        chk("dbz_cleared", {63'd0, dbz1}, 64'd0);
`ifdef MULDIV_EARLY_TERM_EN
        chk("mul6_latency_early", {63'd0, (lat >= 2 && lat <= 4)}, 64'd1);
`else
        chk("mul6_latency", 64'(lat), 64'd33);
`endif
        chk("mul6_exe", EXE_Result, 64'd6);
        tick();

        // Abort a divide at iteration 5
        start = 1'b1; operation = 5'h10; Op1 = 32'd50; Op2 = 32'd7;
        tick();
        start = 1'b0; operation = 5'h00;
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy",  {63'd0, busy},  64'd0);
        chk("abort_done",  {63'd0, done},  64'd0);
        chk("abort_stall", {63'd0, stall}, 64'd0);
        chk("abort_exe",   EXE_Result,     64'd6);
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (done === 1'b1) seen = seen + 1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        $display("abort divide at iteration 5 -> HI=%h LO=%h", HI, LO);

        // Invalid opcode is ignored
        start = 1'b1; operation = 5'h02; Op1 = 32'd1; Op2 = 32'd1;
        #1 chk("badop_stall", {63'd0, stall}, 64'd0);
        tick();
        start = 1'b0;
        chk("badop_busy", {63'd0, busy}, 64'd0);
        tick();
        chk("badop_done", {63'd0, done}, 64'd0);

        // Abort together with start in IDLE: start ignored
        start = 1'b1; operation = 5'h0f; Op1 = 32'd9; Op2 = 32'd9; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0; operation = 5'h00;
        chk("abortstart_busy", {63'd0, busy}, 64'd0);
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (done === 1'b1) seen = seen + 1;
        end
        chk("abortstart_no_done", 64'(seen), 64'd0);
        chk("abortstart_exe", EXE_Result, 64'd6);

        // Small multiply 5 x 3
        run_op(5'h0f, 32'd5, 32'd3, lat, bcnt, st0, dbz1);
`ifdef MULDIV_EARLY_TERM_EN
        chk("mul15_latency_early", {63'd0, (lat >= 2 && lat <= 4)}, 64'd1);
`else
        chk("mul15_latency", 64'(lat), 64'd33);
`endif
        chk("mul15_lo", {32'd0, LO}, 64'd15);
        chk("mul15_hi", {32'd0, HI}, 64'd0);
        tick();

        // Zero multiplier
        run_op(5'h0f, 32'd9, 32'd0, lat, bcnt, st0, dbz1);
`ifdef MULDIV_EARLY_TERM_EN
        chk("mulzero_latency_early", 64'(lat), 64'd2);
`else
        chk("mulzero_latency", 64'(lat), 64'd33);
`endif
        chk("mulzero_exe", EXE_Result, 64'd0);
        tick();

        // Mixed-sign divide with nonzero remainder: -100 / 7 -> q=-14, r=-2
        run_op(5'h10, 32'hFFFF_FF9C, 32'd7, lat, bcnt, st0, dbz1);
        chk("divmix_latency", 64'(lat), 64'd34);
        chk("divmix_exe", EXE_Result, 64'hFFFF_FFFE_FFFF_FFF2);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide engine and controller for the EX stage. Takes over opcodes 5'hf (multiply) and 5'h10 (divide) from the single-cycle ALU.
- Runs a 32-iteration shift-add multiply or restoring divide and holds HI/LO result registers.
- Drives a stall to the hazard unit while busy.
- Result packing matches the ALU: {HI,LO} = 64-bit product, or {remainder, quotient}.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- operation  input  5  5'hf = unsigned multiply, 5'h10 = signed divide; any other value makes start ignored.
- Op1  input  WIDTH  multiplicand / dividend.
- Op2  input  WIDTH  multiplier / divisor.
- abort  input  1  pipeline flush; cancels the operation in flight.
- busy  output  1  high while an operation is in flight.
- stall  output  1  busy OR (start AND valid operation AND IDLE), combinational.
- done  output  1  one-cycle pulse when HI/LO update.
- div_by_zero  output  1  registered; set with done when divisor is 0, cleared at the next accepted start.
- HI  output  WIDTH  product[63:32] or remainder.
- LO  output  WIDTH  product[31:0] or quotient.
- EXE_Result  output  2*WIDTH  {HI,LO}.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - busy, done, div_by_zero = 0.
  - HI = LO = 0.
  - Counter and working registers = 0.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - start with operation 5'hf → MUL. Latch Op1/Op2, counter = 0.
  - start with 5'h10 and Op2 != 0 → DIV. Latch absolute values and both sign bits.
  - start with 5'h10 and Op2 == 0 → DONE directly. Set HI = Op1, LO = all ones, div_by_zero = 1.
  - start with any other operation → stay in IDLE, no response.
- MUL:
  - Each cycle: if multiplier LSB is 1, add multiplicand into the upper half of the 2*WIDTH accumulator.
  - Shift the accumulator/multiplier right by 1; counter += 1.
  - After WIDTH iterations → DONE.
  - Result is the unsigned full 64-bit product; no overflow flag.
- DIV:
  - Restoring divide on magnitudes, one quotient bit per cycle, WIDTH iterations, then → FIX.
- FIX (one cycle):
  - Negate the quotient if the operand signs differ.
  - The remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0 (wrap, no trap).
- DONE (one cycle):
  - Write HI/LO; done = 1; → IDLE.
  - busy falls in this same cycle.
- Latency from the start edge to done:
  - multiply: WIDTH+1 cycles (33).
  - divide: WIDTH+2 cycles (34).
  - divide-by-zero: 1 cycle.
- busy = 1 in MUL, DIV and FIX. It is 0 in IDLE and DONE.
- HI/LO change only in DONE (or at reset). They hold their value otherwise, including across abort.
- Back-to-back operation: start is ignored in DONE. A new start is accepted in the cycle after done, so the minimum issue interval is latency+1.
- abort:
  - In MUL/DIV/FIX: → IDLE next edge, no done, HI/LO unchanged.
  - abort and start together in IDLE: start is ignored.
  - abort in DONE: ignored, and the result commits.
- start while busy: ignored. Operands are already latched, so input changes have no effect.

Optional Feature:
- Macro MULDIV_EARLY_TERM_EN.
- When defined, MUL exits to DONE as soon as the remaining shifted multiplier is zero. The accumulator is aligned by a final shift of (WIDTH − counter) bits, which gives the same product in fewer cycles.
- Multiplier 0 completes in 2 cycles (start edge → MUL, detected zero → DONE).
- Without the macro, multiply always takes the fixed 33 cycles.
- Divide timing is unaffected in both builds.

Test Plan:
- Reset mid-MUL: assert rst at iteration 10 → immediately state IDLE, busy = 0, HI = LO = 0, no done pulse.
- Multiply 0xFFFFFFFF × 0xFFFFFFFF → done on cycle 33; HI = 0xFFFFFFFE, LO = 0x00000001; busy high cycles 1–32, stall high from the start cycle.
- Divide −7 / 2 (0xFFFFFFF9, 0x00000002) → done on cycle 34; LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; then 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Divide 100 / 0 → done the next cycle; div_by_zero = 1, HI = 100, LO = 0xFFFFFFFF; the next valid start clears div_by_zero.
- Abort at divide iteration 5 after a prior multiply left HI:LO = 0x0:0x6 → no done, HI:LO still 0x0:0x6, IDLE next cycle; a start with operation 5'h2 is ignored, busy stays 0.
- With MULDIV_EARLY_TERM_EN: 5 × 3 → done within 4 cycles, LO = 15, HI = 0; without the macro, done on cycle 33 with the same values.
